// File: rtl/game_pkg.sv
// Shared types for the turn-based board game controller.
//   game_state_e : FSM state encoding, also exported on the controller's state port
//   winner_e     : result code exported on the controller's winner port
//   player_win() : maps the mover (0 = P1, 1 = P2) to its winner code
package game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StP1Turn   = 3'd1,
    StP2Turn   = 3'd2,
    StCheck    = 3'd3,
    StGameOver = 3'd4
  } game_state_e;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10,
    WinDraw = 2'b11
  } winner_e;

  function automatic winner_e player_win(input logic player);
    return player ? WinP2 : WinP1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: a prescaler divides clk down to one tick per second and a
// seconds counter counts down from TURN_SEC, stopping at zero.
//   clk, rst     : clock, synchronous active-high reset (reset loads a full turn)
//   load         : restart the turn (prescaler = 0, seconds = TURN_SEC); wins over run
//   run          : advance the prescaler this cycle
//   tick         : prescaler wraps this cycle (one per CLK_HZ running cycles)
//   seconds_left : seconds remaining in the turn
//   expired      : seconds_left has reached zero
module turn_timer #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TURN_SEC = 15,
  parameter int unsigned SW       = $clog2(TURN_SEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  output logic          tick,
  output logic [SW-1:0] seconds_left,
  output logic          expired
);

  // Wide enough for CLK_HZ-1; a 1-bit counter covers the degenerate CLK_HZ = 1 case.
  localparam int unsigned   PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SecInit  = SW'(TURN_SEC);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] secs_q, secs_d;

  assign tick         = run && (presc_q == PrescMax);
  assign expired      = (secs_q == '0);
  assign seconds_left = secs_q;

  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (load) begin
      presc_d = '0;
      secs_d  = SecInit;
    end else if (run) begin
      if (tick) begin
        presc_d = '0;
        // Saturate at zero; the controller decides what expiry means.
        if (secs_q != '0) begin
          secs_d = secs_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      secs_q  <= SecInit;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Two-player N x N board game turn controller (tic-tac-toe style).
// Accepts moves from the player whose turn it is, enforces a per-turn time limit
// with an automatic move into the lowest free cell, and detects wins and draws.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a new game (only honoured in IDLE / GAME_OVER)
//   move_valid   : move request, move_idx = target cell (row-major)
//   move_ready   : controller is in a turn state and can take a move
//   move_reject  : one cycle after a request that was dropped (occupied / out of range)
//   board_p1/p2  : occupancy bitmaps
//   turn         : current player, 0 = P1, 1 = P2
//   seconds_left : seconds remaining in the current turn
//   timeout      : high with the board update caused by an automatic move
//   state        : FSM state code (game_state_e)
//   winner       : winner_e code
//   done         : high in GAME_OVER
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter  int unsigned N        = 3,
  parameter  int unsigned CLK_HZ   = 50_000_000,
  parameter  int unsigned TURN_SEC = 15,
  localparam int unsigned CELLS    = N * N,
  localparam int unsigned IW       = $clog2(CELLS),
  localparam int unsigned SW       = $clog2(TURN_SEC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move_valid,
  input  logic [IW-1:0]    move_idx,
  output logic             move_ready,
  output logic             move_reject,
  output logic [CELLS-1:0] board_p1,
  output logic [CELLS-1:0] board_p2,
  output logic             turn,
  output logic [SW-1:0]    seconds_left,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [1:0]       winner,
  output logic             done
);

  game_state_e      state_q, state_d;
  logic             turn_q, turn_d;
  logic [CELLS-1:0] p1_q, p1_d, p2_q, p2_d;
  winner_e          winner_q, winner_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;

  logic timer_load, timer_run, sec_tick, sec_zero;

  // ---------------------------------------------------------------------------
  // Move legality and automatic-move target
  // ---------------------------------------------------------------------------
  logic             in_turn;
  logic [CELLS-1:0] occupied, free_cells, move_mask, auto_mask;
  logic             idx_in_range, move_legal, board_full;

  assign in_turn      = (state_q == StP1Turn) || (state_q == StP2Turn);
  assign occupied     = p1_q | p2_q;
  assign free_cells   = ~occupied;
  assign board_full   = &occupied;
  assign idx_in_range = 32'(move_idx) < CELLS;
  assign move_legal   = idx_in_range && !occupied[move_idx];

  // Isolate the lowest set bit: x & -x.
  assign auto_mask = free_cells & (~free_cells + 1'b1);

  always_comb begin
    move_mask = '0;
    if (idx_in_range) begin
      move_mask[move_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Win detection on the mover's bitmap (turn has not toggled yet in CHECK)
  // ---------------------------------------------------------------------------
  logic [CELLS-1:0] mover;
  logic [N-1:0]     row_full, col_full, diag_bits, anti_bits;
  logic             line_win;

  assign mover = turn_q ? p2_q : p1_q;

  for (genvar r = 0; r < N; r++) begin : g_row
    assign row_full[r]  = &mover[r*N +: N];
    assign diag_bits[r] = mover[r*N + r];
    assign anti_bits[r] = mover[r*N + (N - 1 - r)];
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [N-1:0] col_bits;
    for (genvar r = 0; r < N; r++) begin : g_cell
      assign col_bits[r] = mover[r*N + c];
    end
    assign col_full[c] = &col_bits;
  end

  assign line_win = (|row_full) || (|col_full) || (&diag_bits) || (&anti_bits);

  // ---------------------------------------------------------------------------
  // Turn timer
  // ---------------------------------------------------------------------------
  turn_timer #(
    .CLK_HZ   (CLK_HZ),
    .TURN_SEC (TURN_SEC),
    .SW       (SW)
  ) u_turn_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (timer_load),
    .run          (timer_run),
    .tick         (sec_tick),
    .seconds_left (seconds_left),
    .expired      (sec_zero)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    winner_d   = winner_q;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;
    timer_load = 1'b0;
    timer_run  = 1'b0;

    unique case (state_q)
      StIdle, StGameOver: begin
        if (start) begin
          p1_d       = '0;
          p2_d       = '0;
          winner_d   = WinNone;
          turn_d     = 1'b0;
          timer_load = 1'b1;
          state_d    = StP1Turn;
        end
      end

      StP1Turn, StP2Turn: begin
        timer_run = 1'b1;
        if (move_valid && move_legal) begin
          // A user move beats a same-cycle expiry.
          if (turn_q) p2_d = p2_q | move_mask;
          else        p1_d = p1_q | move_mask;
          state_d = StCheck;
        end else begin
          reject_d = move_valid;
          if (sec_tick && sec_zero) begin
            if (turn_q) p2_d = p2_q | auto_mask;
            else        p1_d = p1_q | auto_mask;
            timeout_d = 1'b1;
            state_d   = StCheck;
          end
        end
      end

      StCheck: begin
        if (line_win) begin
          winner_d = player_win(turn_q);
          state_d  = StGameOver;
        end else if (board_full) begin
          winner_d = WinDraw;
          state_d  = StGameOver;
        end else begin
          turn_d     = ~turn_q;
          timer_load = 1'b1;
          state_d    = turn_q ? StP1Turn : StP2Turn;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      turn_q    <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      winner_q  <= WinNone;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      winner_q  <= winner_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  assign move_ready  = in_turn;
  assign move_reject = reject_q;
  assign timeout     = timeout_q;
  assign board_p1    = p1_q;
  assign board_p2    = p2_q;
  assign turn        = turn_q;
  assign state       = state_q;
  assign winner      = winner_q;
  assign done        = (state_q == StGameOver);

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 The block SHALL have parameters: N, default 3, board side (board = N*N cells); CLK_HZ, default 50_000_000, clk cycles per second; TURN_SEC, default 15, seconds per turn.
REQ-002 The block SHALL derive localparams CELLS = N*N, IW = $clog2(CELLS), SW = $clog2(TURN_SEC+1).
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or GAME_OVER
- move_valid  in  1  move request
- move_idx  in  IW  target cell, row-major, 0 = top-left
- move_ready  out  1  move accepted this cycle if move_valid
- move_reject  out  1  one-cycle pulse; bad move dropped
- board_p1  out  CELLS  P1 occupancy bitmap
- board_p2  out  CELLS  P2 occupancy bitmap
- turn  out  1  current player (0 = P1, 1 = P2)
- seconds_left  out  SW  turn seconds remaining
- timeout  out  1  one-cycle pulse when an auto-move is made
- state  out  3  FSM state code
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- done  out  1  high in GAME_OVER

Function
REQ-004 The FSM SHALL have states IDLE, P1_TURN, P2_TURN, CHECK and GAME_OVER.
REQ-005 On start in IDLE or GAME_OVER, the block SHALL clear both boards and winner, load seconds_left = TURN_SEC, set turn = 0, and enter P1_TURN next cycle; start SHALL be ignored in all other states.
REQ-006 move_ready SHALL be high only in P1_TURN/P2_TURN.
REQ-007 A move SHALL be accepted when move_valid && move_ready, move_idx < CELLS, and the cell is free in both bitmaps; the current player's bit SHALL be set at the next edge, and the FSM SHALL go to CHECK.
REQ-008 A move with an occupied or out-of-range cell SHALL assert move_reject for one cycle, leave the board unchanged, and keep the state and timer running.
REQ-009 The timer SHALL decrement seconds_left once every CLK_HZ cycles while in a turn state, using a prescaler reset on every turn entry.
REQ-010 When seconds_left is 0 and a prescaler tick occurs without an accepted move, the block SHALL place the current player's mark in the lowest-index free cell, pulse timeout, and go to CHECK.
REQ-011 If a move is accepted in the same cycle as expiry, the user move SHALL win; there SHALL be no auto-move and no timeout pulse.
REQ-012 CHECK SHALL last exactly one cycle.
REQ-013 In CHECK, a full row, column, main diagonal or anti-diagonal of length N owned by the mover SHALL set winner to that player and go to GAME_OVER.
REQ-014 Otherwise in CHECK, if all CELLS are occupied, the block SHALL set winner = 11 and go to GAME_OVER.
REQ-015 Otherwise in CHECK, the block SHALL toggle turn, reload seconds_left = TURN_SEC, and enter the other player's turn state.
REQ-016 Move-to-next-turn latency SHALL be 2 cycles: accept edge, then CHECK edge.
REQ-017 GAME_OVER SHALL hold the boards, winner and done = 1, with the timer frozen, until start or rst.
REQ-018 seconds_left SHALL never wrap below 0.
REQ-019 The prescaler SHALL be wide enough for CLK_HZ-1.

Reset
REQ-020 On rst high at a clk edge, the block SHALL enter IDLE with board_p1 = board_p2 = 0, turn = 0, seconds_left = TURN_SEC, winner = 00, prescaler = 0, and done/timeout/move_reject/move_ready = 0.
REQ-021 rst SHALL override start and move_valid in the same cycle, including mid-game and during CHECK.

Structure
REQ-022 The state enum (IDLE=0, P1_TURN=1, P2_TURN=2, CHECK=3, GAME_OVER=4) and the winner codes SHALL live in shared package game_pkg.
REQ-023 The prescaler and seconds countdown SHALL be sub-module turn_timer, with ports clk, rst, load, run, tick, seconds_left, expired.
REQ-024 Win detection SHALL be combinational, generate-loop based, and correct for any N >= 3.

Verification (CLK_HZ=4, TURN_SEC=3, N=3)
REQ-025 rst mid-P2_TURN with 4 marks placed -> next cycle state=0, boards=0, seconds_left=3, winner=00.
REQ-026 start, then P1 moves 0, 4, 8 interleaved with P2 moves 1, 2 -> after P1's cell-8 CHECK, winner=01, done=1, board_p1=9'h111.
REQ-027 P2 move to an occupied cell 4 -> move_reject pulse, board unchanged, turn=1, timer continues.
REQ-028 No move for 16 cycles in P1_TURN with cells 0-1 taken -> timeout pulse, P1 mark at cell 2, then P2_TURN with seconds_left=3.
REQ-029 Move accepted on the exact expiry cycle -> mark at move_idx only, timeout stays 0.
REQ-030 Fill the board with the sequence 0,1,2,4,3,5,7,6,8 (no line) -> winner=11, done=1; a later start clears the board and gives P1_TURN.
